// File: rtl/param_table_arbiter.sv
// Two-requester round-robin arbiter in front of a read-only parameter lookup table.
// Latency: a response is registered one cycle after its grant cycle; out-of-range indices return 0 with rsp_err.
// Backpressure: single output slot; grants only while the slot is empty or draining this cycle (rsp_ready).
module param_table_arbiter #(
    parameter int ROWS = 2,
    parameter int COLS = 3,
    parameter int W    = 4,
    parameter logic [ROWS-1:0][COLS-1:0][W-1:0] TABLE = {ROWS{W'(6), W'(14), W'(5)}},
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [1:0][RW-1:0]  req_row,
    input  logic [1:0][CW-1:0]  req_col,
    output logic [1:0]          req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic                rsp_id,
    output logic                rsp_err
);

    logic         ptr;
    logic         slot_rdy;
    logic [1:0]   gnt;
    logic         gnt_vld;
    logic         gnt_id;
    logic [RW-1:0] sel_row;
    logic [CW-1:0] sel_col;
    logic [W-1:0] lookup_dat;
    logic         lookup_hit;
    logic [7:0]   gnt_cnt [2];

    assign slot_rdy = !rsp_valid || rsp_ready;

    // Pointer only breaks ties; a lone requester wins regardless of it.
    always_comb begin
        gnt = 2'b00;
        if (!rst && slot_rdy) begin
            if (req_valid == 2'b11) begin
                gnt[ptr] = 1'b1;
            end else begin
                gnt = req_valid;
            end
        end
    end

    assign gnt_vld   = |gnt;
    assign gnt_id    = gnt[1];
    assign req_ready = gnt;
    assign sel_row   = req_row[gnt_id];
    assign sel_col   = req_col[gnt_id];

    // Exhaustive match keeps out-of-range indices from ever addressing the table.
    always_comb begin
        lookup_dat = '0;
        lookup_hit = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (sel_row == RW'(r) && sel_col == CW'(c)) begin
                    lookup_dat = TABLE[r][c];
                    lookup_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (gnt_vld) begin
            rsp_valid <= 1'b1;
            rsp_data  <= lookup_dat;
            rsp_id    <= gnt_id;
            rsp_err   <= !lookup_hit;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (gnt_vld) begin
            ptr <= !gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt[0] <= 8'd0;
            gnt_cnt[1] <= 8'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gnt[i] && gnt_cnt[i] != 8'hff) begin
                    gnt_cnt[i] <= gnt_cnt[i] + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/param_table_arbiter.md
PARAM_TABLE_ARBITER -- requirements
Module: param_table_arbiter

Interface
REQ-001 Parameter ROWS, default 2, number of table rows.
REQ-002 Parameter COLS, default 3, entries per row.
REQ-003 Parameter W, default 4, entry width in bits.
REQ-004 Parameter TABLE, type logic [ROWS-1:0][COLS-1:0][W-1:0], default entries [r][0]=5, [r][1]=14, [r][2]=6 for r=0,1; the block's read-only lookup table.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  2  per-requester request strobe; bit i belongs to requester i.
REQ-008 req_row  input  2x$clog2(ROWS)  per-requester row index.
REQ-009 req_col  input  2x$clog2(COLS)  per-requester column index.
REQ-010 req_ready  output  2  per-requester grant; at most one bit high per cycle.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  downstream accepts the response.
REQ-013 rsp_data  output  W  looked-up entry.
REQ-014 rsp_id  output  1  requester index that owns the response.
REQ-015 rsp_err  output  1  request index was out of range.

Function
REQ-016 A request transfers when req_valid[i] && req_ready[i]; requesters hold row/col stable while valid and unaccepted.
REQ-017 Accept condition: output slot free, i.e. !rsp_valid || rsp_ready (same-cycle drain and refill permitted; full throughput one lookup per cycle).
REQ-018 Grant is combinational from req_valid, priority pointer and accept condition; req_ready is all-zero when the slot cannot accept.
REQ-019 Arbitration is round-robin: if both valid, grant requester named by the priority pointer; if one valid, grant it regardless of the pointer.
REQ-020 After any grant to requester i, pointer becomes 1-i; pointer unchanged in cycles without a grant.
REQ-021 Latency: response appears on rsp_valid exactly one cycle after the grant cycle, with rsp_id = granted index.
REQ-022 rsp_data = TABLE[row][col] for in-range indices, rsp_err=0.
REQ-023 Row >= ROWS or col >= COLS: rsp_data=0, rsp_err=1; response still issued and handshaked normally.
REQ-024 rsp_valid clears on rsp_ready when no new grant occurs that cycle; rsp_data/rsp_id/rsp_err hold stable while rsp_valid && !rsp_ready.
REQ-025 Starvation bound: a continuously valid requester is granted within 2 accept-capable cycles.
REQ-026 A per-requester saturating 8-bit grant counter (internal, exposed to bench via hierarchy) increments on each grant, sticks at 255.

Reset
REQ-027 While rst is high: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, req_ready=0, pointer=0, grant counters=0.
REQ-028 Reset mid-transaction discards any held response; no response from pre-reset grants appears after reset deasserts.
REQ-029 First cycle after reset deassertion the block may grant.

Verification
REQ-030 Single requester: req0 row0 col1, rsp_ready=1 -> req_ready=01 same cycle, next cycle rsp_valid=1, rsp_data=14, rsp_id=0, rsp_err=0.
REQ-031 Contention: both valid continuously (req0 r1c0, req1 r0c2), rsp_ready=1 -> grants alternate 01,10,01,...; responses data 5 id0, 6 id1, alternating, one per cycle.
REQ-032 Backpressure: rsp_ready=0 with rsp_valid=1 -> req_ready=00, rsp fields stable 5+ cycles; raise rsp_ready -> same-cycle drain and new grant.
REQ-033 Out of range: req1 col=3 -> next cycle rsp_err=1, rsp_data=0, rsp_id=1.
REQ-034 Reset mid-operation: assert rst while rsp_valid=1 and both requesting -> all outputs 0 next cycle; after release, first grant goes to requester 0.
REQ-035 Counter saturation: 300 grants to requester 0 -> counter reads 255.
